// File: rtl/mux4_rr_sched.sv
// rtl/mux4_rr_sched.sv - round-robin burst scheduler for a registered 4:1 bit-serial mux
// A burst ends after BURST enabled bits, or early if the granted source drops its request.
module mux4_rr_sched #(
  parameter int BURST = 16,
  parameter int CW    = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ce_i,
  input  logic [3:0] req_i,
  input  logic [3:0] d_i,
  output logic [3:0] gnt_o,
  output logic [1:0] sel_o,
  output logic       q_o,
  output logic       vld_o,
  output logic [3:0] done_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q;
  logic [1:0]      ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      gnt_q;
  logic [1:0]      sel_q;
  logic            q_q;
  logic            vld_q;
  logic [3:0]      done_q;

  logic [1:0]      win;
  logic            win_vld;
  logic [1:0]      idx;

  // First requester found scanning upward from the priority pointer.
  always_comb begin
    win     = ptr_q;
    win_vld = 1'b0;
    idx     = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!win_vld && req_i[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'd0;
      sel_q   <= 2'd0;
      q_q     <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 4'd0;
    end else begin
      vld_q  <= 1'b0;
      done_q <= 4'd0;
      if (ce_i) begin
        case (state_q)
          IDLE: begin
            if (win_vld) begin
              state_q <= BUSY;
              gnt_q   <= 4'b0001 << win;
              sel_q   <= win;
              cnt_q   <= CW'(BURST - 1);
            end
          end
          BUSY: begin
            if (req_i[sel_q]) begin
              q_q   <= d_i[sel_q];
              vld_q <= 1'b1;
              if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
              end else begin
                state_q <= IDLE;
                gnt_q   <= 4'd0;
                done_q  <= 4'b0001 << sel_q;
                ptr_q   <= sel_q + 2'd1;
              end
            end else begin
              // Granted source withdrew: abort without DONE, still rotate priority.
              state_q <= IDLE;
              gnt_q   <= 4'd0;
              ptr_q   <= sel_q + 2'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign gnt_o  = gnt_q;
  assign sel_o  = sel_q;
  assign q_o    = q_q;
  assign vld_o  = vld_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// tb/tb_mux4_rr_sched.sv - directed self-checking bench for mux4_rr_sched with BURST=4
module tb_mux4_rr_sched;

  logic       clk;
  logic       rst;
  logic       ce;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       q;
  logic       vld;
  logic [3:0] done;

  int errors = 0;
  int checks = 0;

  mux4_rr_sched #(.BURST(4), .CW(2)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .ce_i   (ce),
    .req_i  (req),
    .d_i    (d),
    .gnt_o  (gnt),
    .sel_o  (sel),
    .q_o    (q),
    .vld_o  (vld),
    .done_o (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset_state();
    checks++;
    if ({gnt, sel, q, vld, done} !== 12'd0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b sel=%0d q=%b vld=%b done=%b expected all zero", gnt, sel, q, vld, done);
    end
  endtask

  task automatic test_reset();
    req = 4'b0010;
    d   = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010 || vld !== 1'b1 || q !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort: gnt=%b vld=%b q=%b expected 0010 1 1", gnt, vld, q);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, sel, q, vld, done} !== 12'd0) begin
      errors++;
      $display("FAIL async_reset: gnt=%b sel=%0d q=%b vld=%b done=%b expected all zero", gnt, sel, q, vld, done);
    end
    req = 4'b1000;
    d   = 4'b0000;
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000 || sel !== 2'd3 || done !== 4'd0) begin
      errors++;
      $display("FAIL grant_after_reset: gnt=%b sel=%0d done=%b expected 1000 3 0000", gnt, sel, done);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (done !== 4'b1000 || gnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_burst_done: done=%b gnt=%b expected 1000 0000", done, gnt);
    end
    req = 4'd0;
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    logic [3:0] pat;
    pat = 4'b1101;
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'd0 || vld !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: gnt=%b sel=%0d vld=%b expected 0001 0 0", gnt, sel, vld);
    end
    for (int i = 0; i < 4; i++) begin
      d = {3'b000, pat[i]};
      @(negedge clk);
      checks++;
      if (q !== pat[i] || vld !== 1'b1 || done !== ((i == 3) ? 4'b0001 : 4'b0000)
          || gnt !== ((i == 3) ? 4'b0000 : 4'b0001)) begin
        errors++;
        $display("FAIL single_bit%0d: q=%b vld=%b done=%b gnt=%b expected q=%b vld=1", i, q, vld, done, gnt, pat[i]);
      end
    end
    req = 4'd0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'd0 || vld !== 1'b0 || done !== 4'd0) begin
      errors++;
      $display("FAIL single_after: gnt=%b vld=%b done=%b expected 0000 0 0000", gnt, vld, done);
    end
  endtask

  task automatic test_back_to_back();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;
    rst = 1'b1;
    #1 rst = 1'b0;
    req = 4'b1111;
    d   = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << order[k];
      @(negedge clk);
      checks++;
      if (gnt !== exp_g || sel !== 2'(order[k]) || vld !== 1'b0 || done !== 4'd0) begin
        errors++;
        $display("FAIL rr_grant%0d: gnt=%b sel=%0d vld=%b expected gnt=%b vld=0", k, gnt, sel, vld, exp_g);
      end
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        checks++;
        if (vld !== 1'b1 || done !== ((b == 3) ? exp_g : 4'd0)) begin
          errors++;
          $display("FAIL rr_burst%0d_bit%0d: vld=%b done=%b expected vld=1", k, b, vld, done);
        end
      end
    end
    req = 4'd0;
    @(negedge clk);
  endtask

  task automatic test_clock_enable();
    logic [3:0] pat;
    int nvld;
    pat  = 4'b1001;
    nvld = 0;
    req  = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL ce_grant: gnt=%b expected 0001", gnt);
    end
    for (int i = 0; i < 4; i++) begin
      ce = 1'b1;
      d  = {3'b000, pat[i]};
      @(negedge clk);
      if (vld === 1'b1) nvld++;
      checks++;
      if (q !== pat[i] || vld !== 1'b1 || done !== ((i == 3) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL ce_on%0d: q=%b vld=%b done=%b expected q=%b vld=1", i, q, vld, done, pat[i]);
      end
      if (i < 3) begin
        ce = 1'b0;
        d  = {3'b000, ~pat[i]};
        @(negedge clk);
        if (vld === 1'b1) nvld++;
        checks++;
        if (q !== pat[i] || vld !== 1'b0 || done !== 4'd0 || sel !== 2'd0 || gnt !== 4'b0001) begin
          errors++;
          $display("FAIL ce_off%0d: q=%b vld=%b done=%b sel=%0d gnt=%b expected hold q=%b vld=0", i, q, vld, done, sel, gnt, pat[i]);
        end
      end
    end
    checks++;
    if (nvld !== 4) begin
      errors++;
      $display("FAIL ce_valid_count: got %0d expected 4", nvld);
    end
    ce  = 1'b1;
    req = 4'd0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    req = 4'b0100;
    d   = 4'b0000;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || sel !== 2'd2) begin
      errors++;
      $display("FAIL abort_grant: gnt=%b sel=%0d expected 0100 2", gnt, sel);
    end
    repeat (2) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (gnt !== 4'd0 || vld !== 1'b0 || done !== 4'd0) begin
      errors++;
      $display("FAIL abort_drop: gnt=%b vld=%b done=%b expected 0000 0 0000", gnt, vld, done);
    end
    req = 4'b0101;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'd0) begin
      errors++;
      $display("FAIL abort_next: gnt=%b sel=%0d expected 0001 0", gnt, sel);
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (gnt !== 4'd0 || done !== 4'd0) begin
      errors++;
      $display("FAIL abort_second: gnt=%b done=%b expected 0000 0000", gnt, done);
    end
  endtask

  task automatic test_data_select();
    int src[4] = '{1, 3, 0, 2};
    logic exp_q;
    logic [3:0] exp_g;
    d   = 4'b1010;
    req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      exp_g = 4'b0001 << src[k];
      exp_q = (src[k] % 2 == 1);
      @(negedge clk);
      checks++;
      if (gnt !== exp_g) begin
        errors++;
        $display("FAIL data_grant%0d: gnt=%b expected %b", k, gnt, exp_g);
      end
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        checks++;
        if (q !== exp_q || vld !== 1'b1 || done !== ((b == 3) ? exp_g : 4'd0)) begin
          errors++;
          $display("FAIL data_src%0d_bit%0d: q=%b vld=%b done=%b expected q=%b", src[k], b, q, vld, done, exp_q);
        end
      end
      if (k == 1) req = 4'b0101;
    end
    req = 4'd0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    req = 4'd0;
    d   = 4'd0;
    @(negedge clk);
    test_reset_state();
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_clock_enable();
    test_abort();
    test_data_select();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
